// File: rtl/fp4_pkg.sv
// Shared E2M1 FP4 types, code constants, magnitude grid and serializer FSM states.
package fp4_pkg;

  typedef logic [3:0] fp4_t;

  localparam fp4_t       FP4_ZERO    = 4'h0;
  localparam logic [2:0] FP4_MAX_MAG = 3'h7;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  // Magnitude of each E2M1 code in half-units: {0, 0.5, 1, 1.5, 2, 3, 4, 6}
  function automatic logic [3:0] fp4_half_grid(input logic [2:0] mag_code);
    logic [3:0] half;
    case (mag_code)
      3'd0:    half = 4'd0;
      3'd1:    half = 4'd1;
      3'd2:    half = 4'd2;
      3'd3:    half = 4'd3;
      3'd4:    half = 4'd4;
      3'd5:    half = 4'd6;
      3'd6:    half = 4'd8;
      default: half = 4'd12;
    endcase
    return half;
  endfunction

endpackage

// File: rtl/fp4_quantize.sv
// Single-lane signed fixed-point to E2M1 FP4 quantizer: round-to-nearest-even,
// saturating at 6.0, never produces negative zero. Purely combinational.
module fp4_quantize
  import fp4_pkg::*;
#(
  parameter int unsigned IN_W      = 8,
  parameter int unsigned FRAC_BITS = 2
) (
  input  logic [IN_W-1:0] x,
  output fp4_t            code,
  output logic            sat
);

  // Doubled magnitude and grid midpoints in units of 2^-FRAC_BITS; +4 bits covers 6*2^IN_W
  localparam int unsigned CW = IN_W + 4;

  logic            neg;
  logic [IN_W-1:0] mag;
  logic [CW-1:0]   mag2;
  logic [CW-1:0]   mid;
  logic [2:0]      idx;

  always_comb begin
    neg  = x[IN_W-1];
    mag  = neg ? (~x + IN_W'(1)) : x;
    mag2 = CW'(mag) << 1;
    mid  = '0;
    idx  = 3'd0;
    // Each midpoint passed bumps the code; an exact tie only counts when it lands on an even code
    for (int i = 0; i < 7; i++) begin
      mid = (CW'(fp4_half_grid(3'(i))) + CW'(fp4_half_grid(3'(i + 1)))) << (FRAC_BITS - 1);
      if ((mag2 > mid) || ((mag2 == mid) && ((i % 2) == 1))) begin
        idx = idx + 3'd1;
      end
    end
    sat  = mag2 > (CW'(12) << FRAC_BITS);
    code = (idx == 3'd0) ? FP4_ZERO : {neg, idx};
  end

endmodule

// File: rtl/fp4_quant_serializer.sv
// Serializes packed words of signed fixed-point lanes into one E2M1 FP4 code per
// cycle on a valid/ready stream. Define FP4_SAT_COUNT_EN to add o_sat_count.
module fp4_quant_serializer
  import fp4_pkg::*;
#(
  parameter int unsigned LANES     = 4,
  parameter int unsigned IN_W      = 8,
  parameter int unsigned FRAC_BITS = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_word_valid,
  output logic                  o_word_ready,
  input  logic [LANES*IN_W-1:0] i_word,
  output fp4_t                  o_fp4,
  output logic                  o_data_valid,
  output logic                  o_last,
`ifdef FP4_SAT_COUNT_EN
  output logic [15:0]           o_sat_count,
`endif
  input  logic                  i_out_ready
);

  localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  state_t                state_q, state_d;
  logic [LANES*IN_W-1:0] word_q, word_d;
  logic [LANE_W-1:0]     lane_q, lane_d;
  fp4_t                  fp4_d;
  logic                  valid_d, last_d;

  logic                  advance_c, accept_c, at_last_c;
  logic [IN_W-1:0]       lane_arr [LANES];
  logic [IN_W-1:0]       lane_val;
  fp4_t                  q_code, lane_code;
  logic                  q_sat;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      lane_arr[i] = word_q[i*IN_W +: IN_W];
    end
  end

  assign lane_val = lane_arr[lane_q];

  fp4_quantize #(
    .IN_W      (IN_W),
    .FRAC_BITS (FRAC_BITS)
  ) u_quantize (
    .x    (lane_val),
    .code (q_code),
    .sat  (q_sat)
  );

  // Saturated lanes are pinned to max magnitude explicitly, keeping the flag and code consistent
  assign lane_code = q_sat ? fp4_t'({q_code[3], FP4_MAX_MAG}) : q_code;
  assign advance_c = i_out_ready | ~o_data_valid;
  assign at_last_c = (lane_q == LAST_LANE);

  // Next state, buffer/lane update, output-register next values and word handshake
  always_comb begin
    state_d      = state_q;
    word_d       = word_q;
    lane_d       = lane_q;
    fp4_d        = o_fp4;
    valid_d      = o_data_valid;
    last_d       = o_last;
    o_word_ready = 1'b0;
    accept_c     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        o_word_ready = ~i_rst;
        accept_c     = i_word_valid & o_word_ready;
        if (advance_c) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
        end
        if (accept_c) begin
          word_d  = i_word;
          lane_d  = '0;
          state_d = ST_SEND;
        end
      end

      ST_SEND: begin
        o_word_ready = ~i_rst & advance_c & at_last_c;
        accept_c     = i_word_valid & o_word_ready;
        if (advance_c) begin
          fp4_d   = lane_code;
          valid_d = 1'b1;
          last_d  = at_last_c;
          if (!at_last_c) begin
            lane_d = lane_q + LANE_W'(1);
          end else if (accept_c) begin
            word_d = i_word;
            lane_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      word_q       <= '0;
      lane_q       <= '0;
      o_fp4        <= FP4_ZERO;
      o_data_valid <= 1'b0;
      o_last       <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      lane_q       <= lane_d;
      o_fp4        <= fp4_d;
      o_data_valid <= valid_d;
      o_last       <= last_d;
    end
  end

`ifdef FP4_SAT_COUNT_EN
  logic sat_inc_c;

  assign sat_inc_c = (state_q == ST_SEND) & advance_c & q_sat;

  // Counts saturated lanes as they are loaded into the output register; sticks at all-ones
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_sat_count <= '0;
    end else if (sat_inc_c && (o_sat_count != 16'hFFFF)) begin
      o_sat_count <= o_sat_count + 16'd1;
    end
  end
`endif

endmodule
